// File: rtl/pkt_ingress_writer.sv
// Ingress packet writer: allocates a PRT slot, streams words into it, closes it,
// then hands a descriptor (slot, IPs, length, flags) to the bloom-filter stage.
module pkt_ingress_writer #(
    parameter int DATA_WIDTH = 32,
    parameter int NUM_SLOTS  = 16,
    parameter int MAX_WORDS  = 64,
    parameter int SRC_IP_IDX = 3,
    parameter int DST_IP_IDX = 4
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic [DATA_WIDTH-1:0]          s_axis_tdata,
    input  logic                           s_axis_tvalid,
    input  logic                           s_axis_tlast,
    output logic                           s_axis_tready,
    input  logic                           is_prt_slot_free,
    input  logic                           RDY_is_prt_slot_free,
    output logic                           EN_start_writing_prt_entry,
    input  logic                           RDY_start_writing_prt_entry,
    input  logic [$clog2(NUM_SLOTS)-1:0]   start_writing_prt_entry,
    output logic                           EN_write_prt_entry,
    input  logic                           RDY_write_prt_entry,
    output logic [DATA_WIDTH-1:0]          write_prt_entry_data,
    output logic                           EN_finish_writing_prt_entry,
    input  logic                           RDY_finish_writing_prt_entry,
    output logic                           desc_valid,
    input  logic                           desc_ready,
    output logic [$clog2(NUM_SLOTS)-1:0]   desc_slot,
    output logic [31:0]                    desc_src_ip,
    output logic [31:0]                    desc_dst_ip,
    output logic [$clog2(MAX_WORDS):0]     desc_len,
    output logic                           desc_trunc,
    output logic                           desc_runt,
    output logic [15:0]                    trunc_count
);

    localparam int SW = $clog2(NUM_SLOTS);
    localparam int CW = $clog2(MAX_WORDS) + 1;
    localparam logic [CW-1:0] SRC_IDX = CW'(SRC_IP_IDX);
    localparam logic [CW-1:0] DST_IDX = CW'(DST_IP_IDX);
    localparam logic [CW-1:0] MAX_CNT = CW'(MAX_WORDS);

    typedef enum logic [2:0] {
        IDLE, ALLOC, STREAM, DRAIN, FINISH, DESC
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [SW-1:0] slot_q, slot_d;
    logic [31:0]   src_q, src_d, dst_q, dst_d;
    logic          trunc_q, trunc_d, runt_q, runt_d;
    logic [15:0]   tcnt_q, tcnt_d;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        slot_d  = slot_q;
        src_d   = src_q;
        dst_d   = dst_q;
        trunc_d = trunc_q;
        runt_d  = runt_q;
        tcnt_d  = tcnt_q;
        s_axis_tready               = 1'b0;
        EN_start_writing_prt_entry  = 1'b0;
        EN_write_prt_entry          = 1'b0;
        EN_finish_writing_prt_entry = 1'b0;
        desc_valid                  = 1'b0;
        write_prt_entry_data        = s_axis_tdata;

        // Strobes are gated by rst_n so nothing fires while reset is being applied.
        if (rst_n) begin
            unique case (state_q)
                IDLE: if (s_axis_tvalid) state_d = ALLOC;
                ALLOC: begin
                    if (is_prt_slot_free && RDY_is_prt_slot_free && RDY_start_writing_prt_entry) begin
                        EN_start_writing_prt_entry = 1'b1;
                        slot_d  = start_writing_prt_entry;
                        state_d = STREAM;
                    end
                end
                STREAM: begin
                    s_axis_tready = RDY_write_prt_entry;
                    if (s_axis_tvalid && RDY_write_prt_entry) begin
                        EN_write_prt_entry = 1'b1;
                        cnt_d = cnt_q + 1'b1;
                        if (cnt_q == SRC_IDX) src_d = s_axis_tdata[31:0];
                        if (cnt_q == DST_IDX) dst_d = s_axis_tdata[31:0];
                        if (s_axis_tlast) begin
                            state_d = FINISH;
                            runt_d  = (cnt_q < DST_IDX);
                        end else if (cnt_d == MAX_CNT) begin
                            state_d = DRAIN;
                            trunc_d = 1'b1;
                        end
                    end
                end
                DRAIN: begin
                    s_axis_tready = 1'b1;
                    if (s_axis_tvalid && s_axis_tlast) state_d = FINISH;
                end
                FINISH: begin
                    if (RDY_finish_writing_prt_entry) begin
                        EN_finish_writing_prt_entry = 1'b1;
                        state_d = DESC;
                    end
                end
                DESC: begin
                    desc_valid = 1'b1;
                    if (desc_ready) begin
                        state_d = IDLE;
                        cnt_d   = '0;
                        src_d   = '0;
                        dst_d   = '0;
                        trunc_d = 1'b0;
                        runt_d  = 1'b0;
                        if (trunc_q && (tcnt_q != '1)) tcnt_d = tcnt_q + 1'b1;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            slot_q  <= '0;
            src_q   <= '0;
            dst_q   <= '0;
            trunc_q <= 1'b0;
            runt_q  <= 1'b0;
            tcnt_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            slot_q  <= slot_d;
            src_q   <= src_d;
            dst_q   <= dst_d;
            trunc_q <= trunc_d;
            runt_q  <= runt_d;
            tcnt_q  <= tcnt_d;
        end
    end

    assign desc_slot   = slot_q;
    assign desc_src_ip = src_q;
    assign desc_dst_ip = dst_q;
    assign desc_len    = cnt_q;
    assign desc_trunc  = trunc_q;
    assign desc_runt   = runt_q;
    assign trunc_count = tcnt_q;

endmodule

// File: tb/tb_pkt_ingress_writer.sv
// Directed bench for pkt_ingress_writer: inputs change 1ns after posedge,
// outputs are sampled on negedge.
module tb_pkt_ingress_writer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] s_axis_tdata;
    logic        s_axis_tvalid, s_axis_tlast, s_axis_tready;
    logic        is_prt_slot_free, RDY_is_prt_slot_free;
    logic        EN_start_writing_prt_entry, RDY_start_writing_prt_entry;
    logic [3:0]  start_writing_prt_entry;
    logic        EN_write_prt_entry, RDY_write_prt_entry;
    logic [31:0] write_prt_entry_data;
    logic        EN_finish_writing_prt_entry, RDY_finish_writing_prt_entry;
    logic        desc_valid, desc_ready;
    logic [3:0]  desc_slot;
    logic [31:0] desc_src_ip, desc_dst_ip;
    logic [6:0]  desc_len;
    logic        desc_trunc, desc_runt;
    logic [15:0] trunc_count;

    pkt_ingress_writer dut (
        .clk(clk), .rst_n(rst_n),
        .s_axis_tdata(s_axis_tdata), .s_axis_tvalid(s_axis_tvalid),
        .s_axis_tlast(s_axis_tlast), .s_axis_tready(s_axis_tready),
        .is_prt_slot_free(is_prt_slot_free), .RDY_is_prt_slot_free(RDY_is_prt_slot_free),
        .EN_start_writing_prt_entry(EN_start_writing_prt_entry),
        .RDY_start_writing_prt_entry(RDY_start_writing_prt_entry),
        .start_writing_prt_entry(start_writing_prt_entry),
        .EN_write_prt_entry(EN_write_prt_entry), .RDY_write_prt_entry(RDY_write_prt_entry),
        .write_prt_entry_data(write_prt_entry_data),
        .EN_finish_writing_prt_entry(EN_finish_writing_prt_entry),
        .RDY_finish_writing_prt_entry(RDY_finish_writing_prt_entry),
        .desc_valid(desc_valid), .desc_ready(desc_ready), .desc_slot(desc_slot),
        .desc_src_ip(desc_src_ip), .desc_dst_ip(desc_dst_ip), .desc_len(desc_len),
        .desc_trunc(desc_trunc), .desc_runt(desc_runt), .trunc_count(trunc_count)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    logic [31:0] wr_q[$];
    int n_start = 0;
    int n_finish = 0;
    int n_multi_en = 0;
    logic toggle_en = 1'b0;

    always @(negedge clk) begin
        if (EN_write_prt_entry) wr_q.push_back(write_prt_entry_data);
        if (EN_start_writing_prt_entry) n_start++;
        if (EN_finish_writing_prt_entry) n_finish++;
        if (int'(EN_start_writing_prt_entry) + int'(EN_write_prt_entry)
            + int'(EN_finish_writing_prt_entry) > 1) n_multi_en++;
    end

    always @(posedge clk) if (toggle_en) #1 RDY_write_prt_entry = ~RDY_write_prt_entry;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic send_pkt(input int unsigned n, input logic [31:0] base, input logic with_last);
        int guard;
        for (int unsigned i = 0; i < n; i++) begin
            s_axis_tdata  = base + i;
            s_axis_tvalid = 1'b1;
            s_axis_tlast  = with_last && (i == n - 1);
            guard = 0;
            do begin
                @(negedge clk);
                guard++;
            end while (!s_axis_tready && guard < 100);
            if (!s_axis_tready) begin
                chk("beat_timeout", {63'd0, s_axis_tready}, 64'd1);
                s_axis_tvalid = 1'b0;
                s_axis_tlast  = 1'b0;
                return;
            end
            @(posedge clk); #1;
        end
        s_axis_tvalid = 1'b0;
        s_axis_tlast  = 1'b0;
    endtask

    task automatic wait_desc();
        int guard = 0;
        do begin
            @(negedge clk);
            guard++;
        end while (!desc_valid && guard < 200);
        chk("desc_valid_wait", {63'd0, desc_valid}, 64'd1);
    endtask

    task automatic take_desc();
        desc_ready = 1'b1;
        @(posedge clk); #1;
        desc_ready = 1'b0;
    endtask

    task automatic chk_desc(input string tag, input logic [31:0] src, input logic [31:0] dst,
                            input logic [6:0] len, input logic trunc, input logic runt);
        chk({tag, "_src"},   desc_src_ip, src);
        chk({tag, "_dst"},   desc_dst_ip, dst);
        chk({tag, "_len"},   desc_len, len);
        chk({tag, "_trunc"}, desc_trunc, trunc);
        chk({tag, "_runt"},  desc_runt, runt);
    endtask

    initial begin
        int viol;
        logic [31:0] s_src, s_dst;
        logic [6:0]  s_len;
        logic [3:0]  s_slot;
        int start0, fin0;

        rst_n = 1'b0;
        s_axis_tdata = '0; s_axis_tvalid = 1'b0; s_axis_tlast = 1'b0;
        is_prt_slot_free = 1'b1; RDY_is_prt_slot_free = 1'b1;
        RDY_start_writing_prt_entry = 1'b1; start_writing_prt_entry = 4'd5;
        RDY_write_prt_entry = 1'b1; RDY_finish_writing_prt_entry = 1'b1;
        desc_ready = 1'b0;

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_tready", s_axis_tready, 1'b0);
        chk("rst_desc_valid", desc_valid, 1'b0);
        chk("rst_trunc_count", trunc_count, 16'd0);
        @(posedge clk); #1 rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst_en", {EN_start_writing_prt_entry, EN_write_prt_entry,
                            EN_finish_writing_prt_entry}, 3'b000);
        chk("post_rst_valid", desc_valid, 1'b0);
        @(posedge clk); #1;

        // 6-word packet
        wr_q.delete(); n_start = 0; n_finish = 0;
        send_pkt(6, 32'h10, 1'b1);
        wait_desc();
        chk("p6_nwr", wr_q.size(), 6);
        for (int i = 0; i < 6; i++) chk($sformatf("p6_wr%0d", i), wr_q[i], 32'h10 + i);
        chk("p6_nstart", n_start, 1);
        chk("p6_nfinish", n_finish, 1);
        chk("p6_slot", desc_slot, 4'd5);
        chk_desc("p6", 32'h13, 32'h14, 7'd6, 1'b0, 1'b0);
        take_desc();
        @(negedge clk);
        chk("p6_valid_clr", desc_valid, 1'b0);
        @(posedge clk); #1;

        // Slot not free for 5 cycles, then slot 9
        n_start = 0;
        is_prt_slot_free = 1'b0; start_writing_prt_entry = 4'd9;
        s_axis_tdata = 32'h20; s_axis_tvalid = 1'b1;
        viol = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (s_axis_tready || EN_start_writing_prt_entry) viol++;
        end
        chk("alloc_wait_viol", viol, 0);
        @(posedge clk); #1 is_prt_slot_free = 1'b1;
        send_pkt(2, 32'h20, 1'b1);
        wait_desc();
        chk("alloc_nstart", n_start, 1);
        chk("alloc_slot", desc_slot, 4'd9);
        chk_desc("alloc", 32'h0, 32'h0, 7'd2, 1'b0, 1'b1);
        take_desc();

        // 67-word packet: truncated at 64
        wr_q.delete();
        send_pkt(67, 32'h100, 1'b1);
        wait_desc();
        chk("tr_nwr", wr_q.size(), 64);
        chk("tr_wr0", wr_q[0], 32'h100);
        chk("tr_wr63", wr_q[63], 32'h13F);
        chk_desc("tr", 32'h103, 32'h104, 7'd64, 1'b1, 1'b0);
        take_desc();
        @(negedge clk);
        chk("tr_count", trunc_count, 16'd1);
        @(posedge clk); #1;

        // Runt and boundary lengths
        send_pkt(3, 32'h30, 1'b1);
        wait_desc();
        chk_desc("r3", 32'h0, 32'h0, 7'd3, 1'b0, 1'b1);
        take_desc();
        send_pkt(4, 32'h40, 1'b1);
        wait_desc();
        chk_desc("r4", 32'h43, 32'h0, 7'd4, 1'b0, 1'b1);
        take_desc();
        send_pkt(5, 32'h50, 1'b1);
        wait_desc();
        chk_desc("r5", 32'h53, 32'h54, 7'd5, 1'b0, 1'b0);
        take_desc();
        send_pkt(1, 32'h60, 1'b1);
        wait_desc();
        chk_desc("r1", 32'h0, 32'h0, 7'd1, 1'b0, 1'b1);
        take_desc();
        wr_q.delete();
        send_pkt(64, 32'h700, 1'b1);
        wait_desc();
        chk("x64_nwr", wr_q.size(), 64);
        chk_desc("x64", 32'h703, 32'h704, 7'd64, 1'b0, 1'b0);
        take_desc();
        @(negedge clk);
        chk("x64_count", trunc_count, 16'd1);
        @(posedge clk); #1;

        // Toggling write-ready, held descriptor, second packet blocked
        wr_q.delete();
        toggle_en = 1'b1;
        send_pkt(8, 32'h200, 1'b1);
        wait_desc();
        s_src = desc_src_ip; s_dst = desc_dst_ip; s_len = desc_len; s_slot = desc_slot;
        chk("tg_len", s_len, 7'd8);
        chk("tg_src", s_src, 32'h203);
        @(posedge clk); #1;
        s_axis_tdata = 32'h300; s_axis_tvalid = 1'b1;
        viol = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (!desc_valid || desc_src_ip !== s_src || desc_dst_ip !== s_dst
                || desc_len !== s_len || desc_slot !== s_slot || s_axis_tready) viol++;
        end
        chk("tg_hold_viol", viol, 0);
        take_desc();
        send_pkt(2, 32'h300, 1'b1);
        wait_desc();
        chk("tg_nwr", wr_q.size(), 10);
        for (int i = 0; i < 8; i++) chk($sformatf("tg_wr%0d", i), wr_q[i], 32'h200 + i);
        chk("tg_wr8", wr_q[8], 32'h300);
        chk("tg_wr9", wr_q[9], 32'h301);
        chk("tg2_len", desc_len, 7'd2);
        take_desc();
        toggle_en = 1'b0;
        @(posedge clk); #1 RDY_write_prt_entry = 1'b1;

        // Reset mid-packet
        start0 = n_start; fin0 = n_finish;
        send_pkt(3, 32'h400, 1'b0);
        rst_n = 1'b0;
        @(negedge clk);
        chk("mr_in_rst", {s_axis_tready, EN_start_writing_prt_entry, EN_write_prt_entry,
                          EN_finish_writing_prt_entry, desc_valid}, 5'd0);
        @(posedge clk); #1 rst_n = 1'b1;
        @(negedge clk);
        chk("mr_after", {s_axis_tready, EN_start_writing_prt_entry, EN_write_prt_entry,
                         EN_finish_writing_prt_entry, desc_valid}, 5'd0);
        chk("mr_len_clr", desc_len, 7'd0);
        chk("mr_trunc_count", trunc_count, 16'd0);
        chk("mr_nfinish", n_finish, fin0);
        @(posedge clk); #1;
        send_pkt(6, 32'h500, 1'b1);
        wait_desc();
        chk("mr_nstart", n_start, start0 + 2);
        chk_desc("mr", 32'h503, 32'h504, 7'd6, 1'b0, 1'b0);
        take_desc();

        chk("en_onehot", n_multi_en, 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/pkt_ingress_writer.md
PKT_INGRESS_WRITER -- requirements
Module: pkt_ingress_writer

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, stream/PRT word width.
REQ-002 SHALL have parameter NUM_SLOTS, default 16, number of PRT slots.
REQ-003 SHALL have parameter MAX_WORDS, default 64, maximum words stored per packet.
REQ-004 SHALL have parameter SRC_IP_IDX, default 3, word index carrying the source IP.
REQ-005 SHALL have parameter DST_IP_IDX, default 4, word index carrying the destination IP.
REQ-006 SHALL have one clock and a synchronous, active-low reset: clk in 1, rising-edge clock; rst_n in 1, synchronous active-low reset.
REQ-007 SHALL have the following ingress stream ports: s_axis_tdata in DATA_WIDTH; s_axis_tvalid in 1; s_axis_tlast in 1; s_axis_tready out 1.
REQ-008 SHALL have the following PRT allocate ports: is_prt_slot_free in 1; RDY_is_prt_slot_free in 1; EN_start_writing_prt_entry out 1; RDY_start_writing_prt_entry in 1; start_writing_prt_entry in $clog2(NUM_SLOTS), granted slot.
REQ-009 SHALL have the following PRT write ports: EN_write_prt_entry out 1; RDY_write_prt_entry in 1; write_prt_entry_data out DATA_WIDTH.
REQ-010 SHALL have the following PRT close ports: EN_finish_writing_prt_entry out 1; RDY_finish_writing_prt_entry in 1.
REQ-011 SHALL have the following descriptor ports, which feed the bloom-filter stage: desc_valid out 1; desc_ready in 1; desc_slot out $clog2(NUM_SLOTS); desc_src_ip out 32; desc_dst_ip out 32; desc_len out $clog2(MAX_WORDS)+1, words stored; desc_trunc out 1; desc_runt out 1.
REQ-012 SHALL have the status port trunc_count out 16, saturating count of truncated packets.

Function
REQ-013 SHALL implement the FSM states IDLE, ALLOC, STREAM, DRAIN, FINISH, DESC.
REQ-014 IDLE -> ALLOC when s_axis_tvalid=1; no beat is consumed in IDLE.
REQ-015 ALLOC: SHALL assert EN_start_writing_prt_entry for exactly one cycle when is_prt_slot_free & RDY_is_prt_slot_free & RDY_start_writing_prt_entry, SHALL latch start_writing_prt_entry into the slot register in that same cycle, and SHALL then go to STREAM; otherwise it SHALL hold in ALLOC.
REQ-016 STREAM: s_axis_tready SHALL equal RDY_write_prt_entry; on a beat (tvalid & tready), EN_write_prt_entry=1 and write_prt_entry_data=s_axis_tdata in the same cycle (combinational), and the word counter SHALL increment.
REQ-017 Beat at word index SRC_IP_IDX SHALL latch tdata[31:0] into src_ip; beat at index DST_IP_IDX SHALL latch it into dst_ip.
REQ-018 Beat with tlast in STREAM -> FINISH.
REQ-019 Beat making word count = MAX_WORDS without tlast -> DRAIN; trunc flag SHALL be set.
REQ-020 DRAIN: s_axis_tready=1, EN_write_prt_entry=0, beats discarded; beat with tlast -> FINISH.
REQ-021 FINISH: SHALL assert EN_finish_writing_prt_entry for one cycle when RDY_finish_writing_prt_entry=1, then -> DESC.
REQ-022 DESC: desc_valid=1 with all desc_* fields stable until desc_ready=1; on handshake -> IDLE; the counter, flags and IPs SHALL clear.
REQ-023 Runt (tlast at word count <= DST_IP_IDX): desc_runt=1; uncaptured IP fields SHALL read 0.
REQ-024 trunc_count SHALL increment on the DESC handshake when desc_trunc=1 and SHALL saturate at 16'hFFFF.
REQ-025 s_axis_tready SHALL be 0 in IDLE, ALLOC, FINISH and DESC; no new packet is accepted until the descriptor is taken.
REQ-026 At most one EN_* output SHALL be high in any cycle.
REQ-027 desc_len SHALL count stored words only (never more than MAX_WORDS).
REQ-028 Single-word packet (tlast on the first beat) SHALL be legal: desc_len=1, runt=1.

Reset
REQ-029 When rst_n=0 at a clock edge, SHALL enter IDLE and clear the counter, slot, IPs, flags and trunc_count.
REQ-030 During reset and in the first cycle after it, SHALL hold all EN_*, s_axis_tready and desc_valid at 0.
REQ-031 Reset mid-packet SHALL abandon the packet with no finish strobe; PRT cleanup is the PRT's responsibility.

Verification
REQ-032 6-word packet, all RDY=1, words 0x10..0x15 -> 6 EN_write_prt_entry pulses with that data; desc_src_ip=0x13, desc_dst_ip=0x14, desc_len=6, trunc=0, runt=0.
REQ-033 is_prt_slot_free=0 for 5 cycles, then 1 with slot=9 -> tready stays 0 throughout the wait; a single EN_start_writing_prt_entry pulse; desc_slot=9.
REQ-034 MAX_WORDS+3 word packet -> MAX_WORDS writes, 3 beats drained, desc_trunc=1, desc_len=MAX_WORDS, trunc_count=1.
REQ-035 3-word packet -> desc_runt=1, desc_src_ip=0, desc_dst_ip=0, desc_len=3.
REQ-036 RDY_write_prt_entry toggled every cycle, and desc_ready held 0 for 10 cycles -> no lost or duplicated writes; desc fields stable for the 10 cycles; second packet's tready=0 until the handshake.
REQ-037 rst_n=0 asserted after word 2 -> next cycle all outputs 0, FSM in IDLE; a following packet completes normally.
